cq_viola_sysid_checker: RTL and testbench

CQ_VIOLA_SYSID_CHECKER -- requirements
Module: cq_viola_sysid_checker

---
 rtl/cq_viola_sysid_checker.sv | 196 +++++++++++++++++++
 tb/tb_cq_viola_sysid_checker.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cq_viola_sysid_checker.sv
// -----------------------------------------------------------------------------
// cq_viola_sysid_checker
//
// Reads the system ID word (address 0) and the build timestamp word (address 1)
// from an Avalon-MM sysid slave, compares them against the expected values and
// reports the outcome.
// Each read attempt tolerates a bounded number of waitrequest cycles.
// A timed-out attempt is retried after a one-cycle back-off, and the retry
// always starts again from the ID read.
//
// Ports
//   clock            in   single clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   start            in   request one check sequence (sampled only when idle)
//   avm_address      out  word address (0 = ID, 1 = timestamp)
//   avm_read         out  read strobe
//   avm_waitrequest  in   slave stall
//   avm_readdata     in   32-bit read data
//   busy             out  sequence in progress (read or back-off)
//   done             out  one-cycle completion pulse
//   id_ok            out  captured ID matched EXPECTED_ID
//   ts_ok            out  captured timestamp matched EXPECTED_TS
//   timeout_err      out  sequence aborted, retries exhausted
//   id_value         out  last captured ID word
//   ts_value         out  last captured timestamp word
// -----------------------------------------------------------------------------
module cq_viola_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h20150813,
    parameter logic [31:0] EXPECTED_TS    = 32'h55CBFE43,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ID   = 3'd1,
        S_RD_TS   = 3'd2,
        S_BACKOFF = 3'd3,
        S_FIN     = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  retry_q, retry_d;
    logic        rd_q, rd_d;
    logic        addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        timeout_s;

    // The last tolerated stall cycle has been reached and the slave still stalls.
    assign timeout_s = avm_waitrequest && (wait_cnt_q == WAIT_LAST);

    // Next-state, counter and result logic; the bus and status outputs are
    // decoded from the next state so that they leave the flops aligned with it.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        retry_d       = retry_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_err_d = timeout_err_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_RD_ID;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_err_d = 1'b0;
                    wait_cnt_d    = 8'd0;
                    retry_d       = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RD_ID, S_RD_TS: begin
                if (!avm_waitrequest) begin
                    wait_cnt_d = 8'd0;
                    if (state_q == S_RD_ID) begin
                        id_value_d = avm_readdata;
                        state_d    = S_RD_TS;
                    end else begin
                        // id_value_q already holds the ID captured by this attempt.
                        ts_value_d = avm_readdata;
                        id_ok_d    = (id_value_q == EXPECTED_ID);
                        ts_ok_d    = (avm_readdata == EXPECTED_TS);
                        state_d    = S_FIN;
                    end
                end else if (timeout_s) begin
                    wait_cnt_d = 8'd0;
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 3'd1;
                        state_d = S_BACKOFF;
                    end else begin
                        timeout_err_d = 1'b1;
                        id_ok_d       = 1'b0;
                        ts_ok_d       = 1'b0;
                        state_d       = S_FIN;
                    end
                end else begin
                    if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end
            end

            S_BACKOFF: begin
                state_d = S_RD_ID;
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_d   = (state_d == S_RD_ID) || (state_d == S_RD_TS);
        addr_d = (state_d == S_RD_TS);
        busy_d = rd_d || (state_d == S_BACKOFF);
        done_d = (state_d == S_FIN);
    end

    // State, counters, registered bus strobes and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 8'd0;
            retry_q       <= 3'd0;
            rd_q          <= 1'b0;
            addr_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            id_value_q    <= 32'd0;
            ts_value_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            retry_q       <= retry_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_err_q <= timeout_err_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    assign avm_read    = rd_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = timeout_err_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_cq_viola_sysid_checker.sv
// -----------------------------------------------------------------------------
// Testbench for cq_viola_sysid_checker.
// A slave model serves reads from a queue of planned responses.
// A reference model turns every accepted start into a stall/data plan plus the
// expected outcome and completion edge.
// A monitor pops the expected outcome whenever done is seen and compares.
// -----------------------------------------------------------------------------
module tb_cq_viola_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h20150813;
    localparam logic [31:0] EXP_TS = 32'h55CBFE43;
    localparam int          TO     = 16;
    localparam int          MAXR   = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    cq_viola_sysid_checker dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          w;
        logic [31:0] d;
    } req_t;

    typedef struct {
        int          done_edge;
        int          busy_cycles;
        bit          id_ok;
        bit          ts_ok;
        bit          err;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp_t;

    req_t        slave_q[$];
    exp_t        exp_q[$];
    int          cyc       = 0;
    int          next_free = 0;
    int          mode      = 0;
    logic [31:0] m_id      = 32'd0;
    logic [31:0] m_ts      = 32'd0;
    int          n_cmp     = 0;
    int          n_bad     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Stall cycles for one read request; >= TO means the attempt times out.
    function automatic int pick_wait();
        int r;
        case (mode)
            0, 1: return 0;
            2:    return 5;
            3:    return 1000;
            default: begin
                r = $urandom_range(0, 9);
                if (r < 6)       return $urandom_range(0, 3);
                else if (r == 6) return TO - 1;
                else if (r == 7) return TO;
                else if (r == 8) return $urandom_range(4, 9);
                else             return TO + 3;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_data(input logic [31:0] good);
        if ($urandom_range(0, 3) == 0) return $urandom;
        return good;
    endfunction

    // Reference model: plans the slave behaviour for one accepted start at edge n
    // and derives the outcome with attempt-level arithmetic.
    task automatic run_model(input int n);
        exp_t        e;
        int          t       = n;
        int          retries = 0;
        bit          fin     = 0;
        bit          timed;
        int          w;
        logic [31:0] idd;
        logic [31:0] tsd;
        if (mode == 1)      begin idd = 32'h20150814;     tsd = EXP_TS; end
        else if (mode == 4) begin idd = pick_data(EXP_ID); tsd = pick_data(EXP_TS); end
        else                begin idd = EXP_ID;           tsd = EXP_TS; end
        e.err = 0; e.id_ok = 0; e.ts_ok = 0;
        while (!fin) begin
            timed = 0;
            w = pick_wait();
            slave_q.push_back('{w, idd});
            if (w < TO) begin
                t += w + 1;
                m_id = idd;
                w = pick_wait();
                slave_q.push_back('{w, tsd});
                if (w < TO) begin
                    t += w + 1;
                    m_ts = tsd;
                    e.id_ok = (m_id == EXP_ID);
                    e.ts_ok = (tsd == EXP_TS);
                    fin = 1;
                end else begin
                    timed = 1;
                end
            end else begin
                timed = 1;
            end
            if (timed) begin
                t += TO;
                if (retries < MAXR) begin
                    retries++;
                    t += 1;
                end else begin
                    e.err = 1;
                    fin = 1;
                end
            end
        end
        e.done_edge   = t;
        e.busy_cycles = t - n;
        e.idv         = m_id;
        e.tsv         = m_ts;
        exp_q.push_back(e);
        next_free = t + 2;
    endtask

    // Edge counter and start acceptance as the model sees it.
    always @(posedge clock) begin
        cyc++;
        if (!reset_n) begin
            next_free = cyc + 1;
            m_id = 32'd0;
            m_ts = 32'd0;
            slave_q.delete();
            exp_q.delete();
        end else if (start && cyc >= next_free) begin
            run_model(cyc);
        end
    end

    // Slave: serves each new read request from the plan and checks the
    // master holds address while stalled and aborts after exactly TO stalls.
    bit   s_active = 0;
    int   s_cnt    = 0;
    logic s_addr   = 1'b0;
    req_t s_cur;
    always @(negedge clock) begin
        if (!reset_n) begin
            s_active = 0;
            slave_q.delete();
            avm_waitrequest = 1'b0;
            avm_readdata = 32'd0;
        end else if (avm_read) begin
            if (!s_active) begin
                s_active = 1;
                s_cnt = 0;
                s_addr = avm_address;
                if (slave_q.size() == 0) begin
                    chk("unplanned_read", 32'd1, 32'd0);
                    s_cur = '{0, 32'hDEADBEEF};
                end else begin
                    s_cur = slave_q.pop_front();
                end
            end else begin
                chk("addr_stable", {31'd0, avm_address}, {31'd0, s_addr});
            end
            if (s_cnt < s_cur.w) begin
                avm_waitrequest = 1'b1;
                avm_readdata = $urandom;
                s_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata = s_cur.d;
                s_active = 0;
            end
        end else begin
            if (s_active) chk("abort_after_stalls", s_cnt, TO);
            s_active = 0;
            avm_waitrequest = 1'b0;
            avm_readdata = $urandom;
        end
    end

    // Monitor: reset values, and result comparison on every done pulse.
    int   busy_cnt = 0;
    exp_t m_e;
    always @(negedge clock) begin
        if (!reset_n) begin
            busy_cnt = 0;
            chk("reset_flags", {25'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err}, 32'd0);
            chk("reset_id_value", id_value, 32'd0);
            chk("reset_ts_value", ts_value, 32'd0);
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("done_edge", cyc, m_e.done_edge);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                    chk("busy_cycles", busy_cnt, m_e.busy_cycles);
                    chk("id_ok", {31'd0, id_ok}, {31'd0, m_e.id_ok});
                    chk("ts_ok", {31'd0, ts_ok}, {31'd0, m_e.ts_ok});
                    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_e.err});
                    chk("id_value", id_value, m_e.idv);
                    chk("ts_value", ts_value, m_e.tsv);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic run_one(input int m);
        int k = 0;
        wait_idle();
        mode = m;
        while (cyc + 1 < next_free && k < 100) begin
            @(negedge clock);
            k++;
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_one(0);   // zero-wait, good values
        run_one(1);   // wrong ID
        run_one(2);   // 5 stall cycles on each read
        run_one(3);   // slave stuck -> retries exhausted

        // Reset while the timestamp read is outstanding.
        run_one(2);
        k = 0;
        while (!(avm_read && avm_address) && k < 60) begin
            @(negedge clock);
            k++;
        end
        chk("reached_rd_ts", {31'd0, avm_read && avm_address}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_flags", {25'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err}, 32'd0);
        chk("async_reset_id", id_value, 32'd0);
        repeat (2) @(negedge clock);
        #1;
        mode = 0;
        reset_n = 1'b1;
        start = 1'b1;   // must be honoured at the first edge out of reset
        @(negedge clock);
        start = 1'b0;

        // Start held high: back-to-back sequences, no double acceptance.
        wait_idle();
        mode = 0;
        start = 1'b1;
        repeat (10) @(negedge clock);
        start = 1'b0;

        // Randomised traffic.
        wait_idle();
        mode = 4;
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            @(negedge clock);
        end
        start = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
